// File: rtl/dp_seq_pkg.sv
// Shared types and decode helpers for the data-processing sequencer.
// Optional condition evaluation is enabled by DP_SEQ_COND_EN.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RD_N,
    S_RD_M,
    S_EXEC,
    S_WB,
    S_DONE
  } seqState_e;

  localparam logic [3:0] OPC_AND = 4'h0;
  localparam logic [3:0] OPC_EOR = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_RSB = 4'h3;
  localparam logic [3:0] OPC_ADD = 4'h4;
  localparam logic [3:0] OPC_ADC = 4'h5;
  localparam logic [3:0] OPC_SBC = 4'h6;
  localparam logic [3:0] OPC_RSC = 4'h7;
  localparam logic [3:0] OPC_TST = 4'h8;
  localparam logic [3:0] OPC_TEQ = 4'h9;
  localparam logic [3:0] OPC_CMP = 4'hA;
  localparam logic [3:0] OPC_CMN = 4'hB;
  localparam logic [3:0] OPC_ORR = 4'hC;
  localparam logic [3:0] OPC_MOV = 4'hD;
  localparam logic [3:0] OPC_BIC = 4'hE;
  localparam logic [3:0] OPC_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int COND_LSB  = 28;
  localparam int CLASS_LSB = 26;
  localparam int I_BIT     = 25;
  localparam int OPC_LSB   = 21;
  localparam int S_BIT     = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int RM_LSB    = 0;

  function automatic logic isTest(input logic [3:0] opc);
    return opc[3:2] == 2'b10;
  endfunction

  function automatic logic isArith(input logic [3:0] opc);
    return (opc >= OPC_SUB && opc <= OPC_RSC) ||
           opc == OPC_CMP || opc == OPC_CMN;
  endfunction

  function automatic logic isLogical(input logic [3:0] opc);
    return !isArith(opc) && !isTest(opc);
  endfunction

  // imm8 rotated right by twice the 4-bit rotate field
  function automatic logic [31:0] rotImm(input logic [11:0] f);
    logic [31:0] imm;
    logic [5:0]  sh;
    imm = {24'b0, f[7:0]};
    sh  = {1'b0, f[11:8], 1'b0};
    return (imm >> sh) | (imm << (6'd32 - sh));
  endfunction

endpackage

// File: rtl/dp_cond_eval.sv
// ARM condition-code evaluator: pass when cond holds for {N,Z,C,V}.
// Instantiated by the sequencer only when DP_SEQ_COND_EN is defined.
module dp_cond_eval
  import dp_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Multi-cycle ARM data-processing sequencer over a shared ALU and 1R1W RF.
// Define DP_SEQ_COND_EN to honour the condition field.
module dp_instr_sequencer
  import dp_seq_pkg::*;
#(
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_op,
  output logic             alu_cin,
  input  logic [31:0]      alu_out,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic [3:0]       cpsr_nzcv,
  output logic             done,
  output logic             skipped
);

  seqState_e   state;
  logic [31:0] instrReg;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] result;
  logic [3:0]  nzcv;
  logic        condPass;

  logic [1:0] cls;
  logic       immOp;
  logic [3:0] opc;
  logic       setFlags;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] rm;
  logic       noRn;
  logic       testOp;
  logic       execOk;

  assign cls      = instrReg[CLASS_LSB +: 2];
  assign immOp    = instrReg[I_BIT];
  assign opc      = instrReg[OPC_LSB +: 4];
  assign setFlags = instrReg[S_BIT];
  assign rn       = instrReg[RN_LSB +: 4];
  assign rd       = instrReg[RD_LSB +: 4];
  assign rm       = instrReg[RM_LSB +: 4];
  assign noRn     = opc == OPC_MOV || opc == OPC_MVN;
  assign testOp   = isTest(opc);
  assign execOk   = cls == 2'b00 && condPass;

`ifdef DP_SEQ_COND_EN
  dp_cond_eval uCond (
    .cond (instrReg[COND_LSB +: 4]),
    .nzcv (nzcv),
    .pass (condPass)
  );
`else
  logic unusedCond;
  assign unusedCond = ^instrReg[COND_LSB +: 4];
  assign condPass   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      instrReg <= '0;
      opA      <= '0;
      opB      <= '0;
      result   <= '0;
      nzcv     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instrReg <= instr;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!execOk) begin
            state <= S_IDLE;
          end else begin
            if (immOp) opB <= rotImm(instrReg[11:0]);
            if (noRn) state <= immOp ? S_EXEC : S_RD_M;
            else      state <= S_RD_N;
          end
        end
        S_RD_N: begin
          opA   <= rf_rdata;
          state <= immOp ? S_EXEC : S_RD_M;
        end
        S_RD_M: begin
          opB   <= rf_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_out;
          // logical ops keep C and V; tests always update flags
          if (setFlags || testOp) begin
            nzcv[3] <= alu_n;
            nzcv[2] <= alu_z;
            if (isArith(opc)) begin
              nzcv[1] <= alu_c;
              nzcv[0] <= alu_v;
            end
          end
          state <= testOp ? S_DONE : S_WB;
        end
        S_WB:    state <= S_IDLE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpsr_nzcv = nzcv;

  always_comb begin
    instr_ready = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    alu_cin     = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    unique case (state)
      S_IDLE:   instr_ready = 1'b1;
      S_DECODE: skipped = !execOk;
      S_RD_N:   rf_raddr = RF_AW'(rn);
      S_RD_M:   rf_raddr = RF_AW'(rm);
      S_EXEC: begin
        alu_a   = opA;
        alu_b   = opB;
        alu_op  = {1'b0, opc};
        alu_cin = nzcv[1];
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = RF_AW'(rd);
        rf_wdata = result;
        done     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
